// File: rtl/passion_week_sequencer.sv
// Passion-week stimulus generator: walks a 14-step half-day week and drives one
// sequence of event pulses. Optional build macro PASSION_REPEAT_EN reruns it weekly.
module passion_week_sequencer #(
  parameter int CRUCIFY_DAY = 3
) (
  input  logic       i_clk,
  input  logic       i_reset_n,
  input  logic       i_ce,
  input  logic       i_start,
  output logic [3:0] o_time_of_week,
  output logic       o_sabbath,
  output logic       o_preparation_day,
  output logic       o_last_supper,
  output logic       o_gethsemane,
  output logic       o_crucifixion,
  output logic       o_prepare_spices,
  output logic       o_request_guards,
  output logic       o_resurrection,
  output logic       o_tomb_visit,
  output logic       o_busy,
  output logic       o_done
);

  localparam int         C            = CRUCIFY_DAY;
  localparam logic [3:0] SUPPER_STEP  = 4'(2 * C - 1);
  localparam logic [3:0] TOMB_SABBATH = 4'(2 * C + 3);
  localparam logic [3:0] RISEN_STEP   = 4'((2 * C + 8) % 14);
  localparam logic [3:0] PREP_STEP    = 4'd11;
  localparam logic [3:0] VISIT_STEP   = 4'd1;
  localparam logic [3:0] LAST_STEP    = 4'd13;
  localparam logic [2:0] SABBATH_DAY  = 3'd6;

  // State names the phase of the step currently on the outputs.
  typedef enum logic [2:0] {
    IDLE, WAIT, SUPPER, GARDEN, CROSS, TOMB, RISEN, DONE
  } state_e;

  typedef struct packed {
    logic sabbath;
    logic preparation_day;
    logic last_supper;
    logic gethsemane;
    logic crucifixion;
    logic prepare_spices;
    logic request_guards;
    logic resurrection;
    logic tomb_visit;
    logic busy;
  } out_t;

  state_e     state_q, state_d;
  logic [3:0] step_q, step_d;
  out_t       out_q, out_d;
  logic       spiced_q, spiced_d;
  logic       guard_pend_q, guard_pend_d;
  logic       guarded_q, guarded_d;
  logic       accept;
  logic       day_step;
  logic       spice_ok;

  always_comb begin
    // NOTE: every target gets a default before any branch, so no latch is inferred.
    step_d       = (step_q == LAST_STEP) ? 4'd0 : step_q + 4'd1;
    state_d      = state_q;
    spiced_d     = spiced_q;
    guard_pend_d = guard_pend_q;
    guarded_d    = guarded_q;
    out_d        = '0;

    day_step = step_d[0];
    accept   = (state_q == IDLE) && !out_q.busy && i_start;

    // The two steps right after the crucifixion form the extra sabbath.
    out_d.sabbath = (step_d[3:1] == SABBATH_DAY) || (state_q == CROSS) ||
                    ((state_q == TOMB) && (step_d == TOMB_SABBATH));
    spice_ok      = !spiced_q && day_step && !out_d.sabbath;

    if (guard_pend_q && day_step) begin
      out_d.request_guards = 1'b1;
      guard_pend_d         = 1'b0;
      guarded_d            = 1'b1;
    end

    unique case (state_q)
      IDLE, WAIT: begin
        if (accept || (state_q == WAIT)) begin
          if (step_d == SUPPER_STEP) begin
            out_d.last_supper = 1'b1;
            state_d           = SUPPER;
          end else begin
            state_d = WAIT;
          end
        end
      end
      SUPPER: begin
        out_d.gethsemane = 1'b1;
        state_d          = GARDEN;
      end
      GARDEN: begin
        out_d.crucifixion = 1'b1;
        guard_pend_d      = 1'b1;
        state_d           = CROSS;
      end
      CROSS: state_d = TOMB;
      TOMB: begin
        if (step_d == RISEN_STEP) begin
          out_d.resurrection = 1'b1;
          state_d            = RISEN;
        end else if (spice_ok) begin
          out_d.prepare_spices = 1'b1;
          spiced_d             = 1'b1;
        end
      end
      RISEN, DONE: begin
        state_d = DONE;
        if (spice_ok) begin
          out_d.prepare_spices = 1'b1;
          spiced_d             = 1'b1;
        end
        // A visit that is not yet possible simply waits for a later Sunday.
        if ((step_d == VISIT_STEP) && spiced_d && guarded_d) begin
          out_d.tomb_visit = 1'b1;
          spiced_d         = 1'b0;
          guarded_d        = 1'b0;
`ifdef PASSION_REPEAT_EN
          state_d          = WAIT;
`else
          state_d          = IDLE;
`endif
        end
      end
      default: state_d = IDLE;
    endcase

    out_d.preparation_day = (step_d == PREP_STEP) || out_d.crucifixion;
    out_d.busy            = (state_d != IDLE) || out_d.tomb_visit;
  end

  always_ff @(posedge i_clk) begin
    // NOTE: synchronous reset wins over i_ce; state is written non-blocking only.
    if (!i_reset_n) begin
      state_q      <= IDLE;
      step_q       <= 4'd0;
      out_q        <= '0;
      spiced_q     <= 1'b0;
      guard_pend_q <= 1'b0;
      guarded_q    <= 1'b0;
    end else if (i_ce) begin
      state_q      <= state_d;
      step_q       <= step_d;
      out_q        <= out_d;
      spiced_q     <= spiced_d;
      guard_pend_q <= guard_pend_d;
      guarded_q    <= guarded_d;
    end
  end

  assign o_time_of_week    = step_q;
  assign o_sabbath         = out_q.sabbath;
  assign o_preparation_day = out_q.preparation_day;
  assign o_last_supper     = out_q.last_supper;
  assign o_gethsemane      = out_q.gethsemane;
  assign o_crucifixion     = out_q.crucifixion;
  assign o_prepare_spices  = out_q.prepare_spices;
  assign o_request_guards  = out_q.request_guards;
  assign o_resurrection    = out_q.resurrection;
  assign o_tomb_visit      = out_q.tomb_visit;
  assign o_busy            = out_q.busy;
  assign o_done            = out_q.tomb_visit;

endmodule
